alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single 32-bit ALU between up to NREQ requesters (e.g. the main datapath, branch-compare unit, address-generation helper) using per-requester valid/ready handshakes. A round-robin arbiter grants one request at a time, latches its operands and opcode, drives the shared ALU, registers the result and flags, and returns them with the requester ID on a single response channel. It sits directly in front of the ALU; the ALU itself is unchanged and purely combinational.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- IDW, $clog2(NREQ), width of requester ID
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle
- req_op  in  NREQ*3  flattened opcodes, requester i at [3i+2:3i]
- req_a, req_b  in  NREQ*WIDTH  flattened operands, requester i at [WIDTH*i+WIDTH-1:WIDTH*i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  requester that issued the response
- rsp_result  out  WIDTH  captured ALU result
- rsp_zero, rsp_lt, rsp_gt  out  1 each  captured ALU flags
- alu_data1, alu_data2  out  WIDTH  operands to ALU
- alu_op  out  3  opcode to ALU
- alu_result  in  WIDTH;  alu_zero, alu_lt, alu_gt  in  1 each  ALU outputs

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, select winner by round-robin starting at rr_ptr; assert req_ready[winner] combinationally this cycle; on the edge latch op/a/b/id into operand registers, go EXEC. No valid -> stay IDLE, req_ready all zero.
- EXEC: alu_op/alu_data1/alu_data2 driven from operand registers; on the edge capture alu_result and flags into rsp registers, go RESP.
- RESP: rsp_valid=1, rsp_* stable. rsp_ready=1 -> go IDLE, rr_ptr = (id+1) mod NREQ. rsp_ready=0 -> hold indefinitely; no new request accepted.
- In IDLE/RESP, ALU inputs hold the last latched operands (no toggling).
- Opcodes passed through unmodified (000 ADD, 001 SUB, 010 AND, 011 OR, 100 unsigned greater-than -> 1/0, others ADD); arbiter does not interpret them.
- Requester deasserting req_valid without a ready is legal; it simply loses eligibility.
- Requester must hold op/a/b stable only during its req_ready cycle.

## Timing
- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero/lt/gt 0, alu_op 000, alu_data1/2 0.
- Latency: accept at cycle T -> rsp_valid at T+2.
- Throughput: one op per 3 cycles minimum (IDLE, EXEC, RESP); rsp_ready cycle in RESP and next accept never overlap.
- rst high mid-operation (EXEC or RESP): in-flight op dropped, all outputs to reset values next edge.
- Simultaneous requests: exactly one granted; others wait; a continuously requesting agent is granted within NREQ arbitration rounds.

## Configuration
- ALU_ARB_PRIO_EN defined: requester 0 has fixed highest priority over all others whenever its req_valid is high in IDLE; requesters 1..NREQ-1 round-robin among themselves; rr_ptr never points at 0.
- Undefined: pure round-robin over all NREQ requesters as above.

## Structure
- Shared package alu_pkg: ALU opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_GT), FSM state typedef arb_state_t.
- One sub-module: rr_pick (combinational round-robin selector: valid vector + pointer -> one-hot grant + index), instantiated once.

## Test plan
- Reset: drive rst 2 cycles with all req_valid=1 -> all outputs zero, req_ready=0, state IDLE.
- Single request: req 2 ADD a=5,b=7 at T -> req_ready=0100 at T, rsp_valid at T+2 with id=2, result=12, zero=0, gt=0, lt=1.
- Contention: all 4 requesters valid continuously with SUB a=3,b=3, rsp_ready=1 -> grants in order 0,1,2,3,0, each result 0 with rsp_zero=1, one grant per 3 cycles.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* constant, req_ready stays 0; rsp_ready=1 -> IDLE next cycle.
- Reset mid-EXEC: req 1 OR a=0xF0,b=0x0F, rst asserted in EXEC -> no rsp_valid, rsp_result=0, rr_ptr=0.
- ALU_ARB_PRIO_EN: requesters 0 and 3 both valid while rr_ptr=3 -> grant 0; without macro -> grant 3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode encodings and FSM states.
// Opcodes are documented here for requesters; the arbiter itself never decodes them.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_GT  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Wrap-around increment of a requester index within [lo, n-1].
  function automatic int next_index(input int idx, input int n, input int lo);
    return (idx >= n - 1) ? lo : idx + 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid bit at or after the pointer,
// wrapping around, reported as a one-hot grant plus its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int   j;
  logic found;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && valid_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ valid/ready requesters.
// Optional build macro ALU_ARB_PRIO_EN: requester 0 gets fixed top priority.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*3-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_lt,
  output logic                  rsp_gt,
  output logic [WIDTH-1:0]      alu_data1,
  output logic [WIDTH-1:0]      alu_data2,
  output logic [2:0]            alu_op,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_gt
);

`ifdef ALU_ARB_PRIO_EN
  localparam int RR_LO = 1;
`else
  localparam int RR_LO = 0;
`endif
  localparam logic [IDW-1:0] PTR_RESET = IDW'(RR_LO);

  arb_state_t        state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic              rsp_zero_q, rsp_lt_q, rsp_gt_q;

  logic [NREQ-1:0]   pick_valid, pick_grant;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic [NREQ-1:0]   win_grant;
  logic [IDW-1:0]    win_idx;
  logic              win_any;
  logic              accept;

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr_pick (
    .valid_i (pick_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Winner selection; with priority enabled requester 0 bypasses the rotation.
  always_comb begin
    pick_valid = req_valid;
    win_grant  = pick_grant;
    win_idx    = pick_idx;
    win_any    = pick_any;
`ifdef ALU_ARB_PRIO_EN
    pick_valid[0] = 1'b0;
    if (req_valid[0]) begin
      win_grant = NREQ'(1);
      win_idx   = '0;
      win_any   = 1'b1;
    end
`endif
  end

  assign accept   = (state_q == IDLE) && !rst && win_any;
  assign rr_ptr_d = IDW'(next_index(int'(id_q), NREQ, RR_LO));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; req_ready is suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = rst ? '0 : win_grant;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand, pointer and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= PTR_RESET;
      id_q         <= '0;
      op_q         <= ALU_ADD;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_gt_q     <= 1'b0;
    end else begin
      if (accept) begin
        id_q <= win_idx;
        op_q <= req_op[int'(win_idx)*3 +: 3];
        a_q  <= req_a[int'(win_idx)*WIDTH +: WIDTH];
        b_q  <= req_b[int'(win_idx)*WIDTH +: WIDTH];
      end
      if (state_q == EXEC) begin
        rsp_id_q     <= id_q;
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_lt_q     <= alu_lt;
        rsp_gt_q     <= alu_gt;
      end
      if (state_q == RESP && rsp_ready) begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  // ALU inputs always reflect the last latched operands, so they never toggle in IDLE/RESP.
  assign alu_op     = op_q;
  assign alu_data1  = a_q;
  assign alu_data2  = b_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_lt     = rsp_lt_q;
  assign rsp_gt     = rsp_gt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised self-checking bench for alu_share_arbiter with a transaction-level model
// and a behavioural ALU; also honours ALU_ARB_PRIO_EN when defined.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero, rsp_lt, rsp_gt;
  logic [WIDTH-1:0]      alu_data1, alu_data2, alu_result;
  logic [2:0]            alu_op;
  logic                  alu_zero, alu_lt, alu_gt;

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_lt     (rsp_lt),
    .rsp_gt     (rsp_gt),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .alu_gt     (alu_gt)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a, b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_GT:  return (a > b) ? WIDTH'(1) : WIDTH'(0);
      default: return a + b;
    endcase
  endfunction

  // The shared ALU the arbiter fronts.
  always_comb begin
    alu_result = alu_fn(alu_op, alu_data1, alu_data2);
    alu_zero   = (alu_result == '0);
    alu_lt     = (alu_data1 < alu_data2);
    alu_gt     = (alu_data1 > alu_data2);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding op, released when its response is taken.
`ifdef ALU_ARB_PRIO_EN
  localparam int RR_LO = 1;
`else
  localparam int RR_LO = 0;
`endif
  bit               m_pending;
  int               m_age;
  int               m_ptr, m_id;
  logic [2:0]       m_op;
  logic [WIDTH-1:0] m_a, m_b;
  int               m_rsp_id;
  logic [WIDTH-1:0] m_rsp_res;
  logic [2:0]       m_flags;
  int               cyc = 0;
  int               grants[$];
  int               grant_cyc[$];

  function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
`ifdef ALU_ARB_PRIO_EN
    if (v[0]) return 0;
    for (int k = 0; k < NREQ - 1; k++) begin
      int i;
      i = 1 + ((ptr - 1 + k) % (NREQ - 1));
      if (v[i]) return i;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_age = 0; m_ptr = RR_LO; m_id = 0;
    m_op = 3'b000; m_a = '0; m_b = '0;
    m_rsp_id = 0; m_rsp_res = '0; m_flags = 3'b000;
  endtask

  // Called at a falling edge with inputs already driven: check, advance model, wait.
  task automatic tick();
    int w;
    logic [NREQ-1:0] exp_ready;
    #1;
    w = m_pending ? -1 : model_winner(req_valid, m_ptr);
    exp_ready = (rst || w < 0) ? '0 : NREQ'(1) << w;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(m_pending && m_age == 2));
    check("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
    check("rsp_result", 64'(rsp_result), 64'(m_rsp_res));
    check("rsp_flags", 64'({rsp_zero, rsp_lt, rsp_gt}), 64'(m_flags));
    check("alu_in", {alu_op, 29'd0, alu_data1}, {m_op, 29'd0, m_a});
    check("alu_data2", 64'(alu_data2), 64'(m_b));
    if (req_ready != '0) begin
      grants.push_back($clog2(req_ready));
      grant_cyc.push_back(cyc);
    end
    if (rst) begin
      model_reset();
    end else if (m_pending) begin
      if (m_age == 1) begin
        m_age     = 2;
        m_rsp_id  = m_id;
        m_rsp_res = alu_fn(m_op, m_a, m_b);
        m_flags   = {m_rsp_res == '0, m_a < m_b, m_a > m_b};
      end else if (rsp_ready) begin
        m_pending = 0;
        m_ptr     = (m_id + 1) % NREQ;
        if (m_ptr < RR_LO) m_ptr = RR_LO;
      end
    end else if (w >= 0) begin
      m_pending = 1; m_age = 1; m_id = w;
      m_op = req_op[3*w +: 3];
      m_a  = req_a[WIDTH*w +: WIDTH];
      m_b  = req_b[WIDTH*w +: WIDTH];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic rdy);
    req_valid = v;
    rsp_ready = rdy;
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]         = op;
      req_a[WIDTH*i +: WIDTH]  = a;
      req_b[WIDTH*i +: WIDTH]  = b;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    rst = 1'b1;
    drive('1, ALU_ADD, 32'd1, 32'd2, 1'b1);
    @(negedge clk);
    model_reset();

    // Reset held two cycles with every requester valid.
    tick(); tick();
    #1;
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_rsp", {31'd0, rsp_valid, rsp_result}, 64'(0));
    rst = 1'b0;
    drive('0, ALU_ADD, 0, 0, 1'b1);
    tick();

    // Single request from requester 2.
    drive(4'b0100, ALU_ADD, 32'd5, 32'd7, 1'b1);
    #1 check("single_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    #1;
    check("single_valid", 64'(rsp_valid), 64'(1));
    check("single_id", 64'(rsp_id), 64'(2));
    check("single_res", 64'(rsp_result), 64'(12));
    check("single_flags", 64'({rsp_zero, rsp_lt, rsp_gt}), 64'(3'b010));
    tick();

    // Contention from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    drive('1, ALU_SUB, 32'd3, 32'd3, 1'b1);
    grants.delete(); grant_cyc.delete();
    repeat (15) tick();
    if (grants.size() < 5) begin
      check("cont_count", 64'(grants.size()), 64'(5));
    end else begin
      for (int i = 0; i < 5; i++) check("cont_order", 64'(grants[i]), 64'(i % NREQ));
      for (int i = 1; i < 5; i++) check("cont_gap", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(3));
    end
    drive('0, ALU_ADD, 0, 0, 1'b1);
    repeat (3) tick();

    // Backpressure on the response channel.
    rst = 1'b1; tick(); rst = 1'b0;
    drive(4'b0001, ALU_ADD, 32'd9, 32'd1, 1'b0);
    tick();
    req_valid = '1;
    tick();
    #1 held = rsp_result;
    check("bp_first", 64'(held), 64'(10));
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold", {31'd0, rsp_valid, rsp_result}, {31'd0, 1'b1, 32'd10});
      check("bp_ready", 64'(req_ready), 64'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    check("bp_idle_valid", 64'(rsp_valid), 64'(0));
    check("bp_idle_grant", 64'(req_ready), 64'(4'b0010));
    req_valid = '0;
    tick();

    // Reset while in EXEC drops the operation.
    drive(4'b0010, ALU_OR, 32'hF0, 32'h0F, 1'b1);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    #1;
    check("rexec_valid", 64'(rsp_valid), 64'(0));
    check("rexec_res", 64'(rsp_result), 64'(0));
    req_valid = '1;
    #1 check("rexec_ptr", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    tick();

    // Requesters 0 and 3 contend with the pointer at 3.
    rst = 1'b1; tick(); rst = 1'b0;
    drive(4'b0100, ALU_AND, 32'hFF, 32'h0F, 1'b1);
    tick(); req_valid = '0; tick(); tick();
    req_valid = 4'b1001;
`ifdef ALU_ARB_PRIO_EN
    #1 check("prio_grant", 64'(req_ready), 64'(4'b0001));
`else
    #1 check("prio_grant", 64'(req_ready), 64'(4'b1000));
`endif
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 249) == 0);
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        req_op[3*i +: 3]        = 3'($urandom);
        req_a[WIDTH*i +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : $urandom;
        req_b[WIDTH*i +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
